// File: rtl/spmv_row_streamer_if.sv
// Matrix-memory read bus between the row streamer and the group memory.
// master: drives read strobe and group address, receives the lane data.
// slave:  returns mem_rdata one cycle after each mem_rd.
//   mem_rd     read strobe
//   mem_addr   group word address
//   mem_rdata  per lane {value[95:64], col[63:32], row[31:0]}
interface spmv_row_streamer_if #(
    parameter int unsigned NUM_CHANNELS = 4,
    parameter int unsigned ADDR_W       = 10
);
    logic                           mem_rd;
    logic [ADDR_W-1:0]              mem_addr;
    logic [NUM_CHANNELS-1:0][95:0]  mem_rdata;

    modport master (output mem_rd, output mem_addr, input  mem_rdata);
    modport slave  (input  mem_rd, input  mem_addr, output mem_rdata);
endinterface

// File: rtl/spmv_row_streamer.sv
// Streams the nonzeros of a sparse matrix out of memory, one group of
// NUM_CHANNELS lanes per cycle, padding the tail group and signalling the
// end of stream with row_id == MATRIX_SIZE on every lane.
// Ports:
//   clk, rst_l           clock, async active-low reset
//   start                begin a stream (accepted in IDLE or DONE only)
//   base_addr, nnz       first group address and total nonzero count
//   mem                  matrix memory read bus (master side)
//   values/col_id/row_id registered lane outputs
//   rdy                  lane outputs carry a group this cycle
//   busy, done           FETCH/DRAIN and DONE indicators
module spmv_row_streamer #(
    parameter int unsigned NUM_CHANNELS = 4,
    parameter int unsigned MATRIX_SIZE  = 128,
    parameter int unsigned ADDR_W       = 10
) (
    input  logic                          clk,
    input  logic                          rst_l,
    input  logic                          start,
    input  logic [ADDR_W-1:0]             base_addr,
    input  logic [31:0]                   nnz,
    spmv_row_streamer_if.master           mem,
    output logic [NUM_CHANNELS-1:0][31:0] values,
    output logic [NUM_CHANNELS-1:0][31:0] col_id,
    output logic [NUM_CHANNELS-1:0][31:0] row_id,
    output logic                          rdy,
    output logic                          busy,
    output logic                          done
);
    localparam int unsigned CNT_W    = $clog2(NUM_CHANNELS + 1);
    localparam logic [31:0] SENTINEL = 32'(MATRIX_SIZE);
    localparam logic [31:0] LANES    = 32'(NUM_CHANNELS);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_e;

    state_e                         state_q, state_d;
    logic                           mem_rd_q, mem_rd_d;
    logic [ADDR_W-1:0]              mem_addr_q, mem_addr_d;
    // Nonzeros not yet issued; reaching zero marks the last group.
    logic [31:0]                    rem_q, rem_d;
    // Valid-lane count of the group currently being issued.
    logic [CNT_W-1:0]               cur_cnt_q, cur_cnt_d;
    // Read-data stage: data on mem_rdata this cycle and its valid-lane count.
    logic                           p1_v_q;
    logic [CNT_W-1:0]               p1_cnt_q;
    logic [NUM_CHANNELS-1:0][31:0]  values_q, values_d;
    logic [NUM_CHANNELS-1:0][31:0]  col_q, col_d;
    logic [NUM_CHANNELS-1:0][31:0]  row_q, row_d;
    logic                           rdy_q, rdy_d;

    // Valid lanes in a group given the nonzeros still to issue.
    function automatic logic [CNT_W-1:0] lanes_of(input logic [31:0] r);
        return (r >= LANES) ? CNT_W'(NUM_CHANNELS) : CNT_W'(r);
    endfunction

    // Next-state, read issue and output formatting.
    always_comb begin
        state_d    = state_q;
        mem_rd_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        rem_d      = rem_q;
        cur_cnt_d  = cur_cnt_q;
        rdy_d      = 1'b0;
        values_d   = '0;
        col_d      = '0;
        row_d      = '0;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    cur_cnt_d = lanes_of(nnz);
                    rem_d     = nnz - 32'(lanes_of(nnz));
                    if (nnz != 32'd0) begin
                        state_d    = FETCH;
                        mem_rd_d   = 1'b1;
                        mem_addr_d = base_addr;
                    end else begin
                        state_d = DRAIN;
                    end
                end
            end
            FETCH: begin
                if (rem_q == 32'd0) begin
                    state_d = DRAIN;
                end else begin
                    mem_rd_d   = 1'b1;
                    mem_addr_d = mem_addr_q + ADDR_W'(1);
                    cur_cnt_d  = lanes_of(rem_q);
                    rem_d      = rem_q - 32'(lanes_of(rem_q));
                end
            end
            DRAIN: begin
                // Leave once no read is outstanding and no data is in the stage.
                if (!mem_rd_q && !p1_v_q) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (p1_v_q) begin
            rdy_d = 1'b1;
            for (int unsigned k = 0; k < NUM_CHANNELS; k++) begin
                if (CNT_W'(k) < p1_cnt_q) begin
                    values_d[k] = mem.mem_rdata[k][95:64];
                    col_d[k]    = mem.mem_rdata[k][63:32];
                    row_d[k]    = mem.mem_rdata[k][31:0];
                end else begin
                    row_d[k]    = SENTINEL;
                end
            end
        end else if (state_d == DONE) begin
            // End-of-stream marker, held for as long as we stay in DONE.
            for (int unsigned k = 0; k < NUM_CHANNELS; k++) begin
                row_d[k] = SENTINEL;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q    <= IDLE;
            mem_rd_q   <= 1'b0;
            mem_addr_q <= '0;
            rem_q      <= '0;
            cur_cnt_q  <= '0;
            p1_v_q     <= 1'b0;
            p1_cnt_q   <= '0;
            values_q   <= '0;
            col_q      <= '0;
            row_q      <= '0;
            rdy_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            mem_rd_q   <= mem_rd_d;
            mem_addr_q <= mem_addr_d;
            rem_q      <= rem_d;
            cur_cnt_q  <= cur_cnt_d;
            p1_v_q     <= mem_rd_q;
            p1_cnt_q   <= cur_cnt_q;
            values_q   <= values_d;
            col_q      <= col_d;
            row_q      <= row_d;
            rdy_q      <= rdy_d;
        end
    end

    assign mem.mem_rd   = mem_rd_q;
    assign mem.mem_addr = mem_addr_q;
    assign values       = values_q;
    assign col_id       = col_q;
    assign row_id       = row_q;
    assign rdy          = rdy_q;
    assign busy         = (state_q == FETCH) || (state_q == DRAIN);
    assign done         = (state_q == DONE);
endmodule

// File: tb/tb_spmv_row_streamer.sv
// Directed bench for spmv_row_streamer with a one-cycle-latency memory model.
module tb_spmv_row_streamer;
    localparam int unsigned NC = 4;
    localparam int unsigned MS = 128;
    localparam int unsigned AW = 10;

    typedef logic [NC-1:0][31:0] lanes_t;
    typedef logic [NC-1:0][95:0] mem_t;

    localparam lanes_t SENT = {NC{32'd128}};

    logic           clk = 1'b0;
    logic           rst_l = 1'b0;
    logic           start = 1'b0;
    logic [AW-1:0]  base_addr = '0;
    logic [31:0]    nnz = '0;
    lanes_t         values, col_id, row_id;
    logic           rdy, busy, done;

    int cyc = 0;
    int tests_run = 0;
    int tests_failed = 0;

    int     rd_addr_q[$];
    int     rd_cyc_q[$];
    int     out_cyc_q[$];
    lanes_t out_val_q[$];
    lanes_t out_col_q[$];
    lanes_t out_row_q[$];

    spmv_row_streamer_if #(.NUM_CHANNELS(NC), .ADDR_W(AW)) mif ();

    spmv_row_streamer #(.NUM_CHANNELS(NC), .MATRIX_SIZE(MS), .ADDR_W(AW)) dut (
        .clk       (clk),
        .rst_l     (rst_l),
        .start     (start),
        .base_addr (base_addr),
        .nnz       (nnz),
        .mem       (mif),
        .values    (values),
        .col_id    (col_id),
        .row_id    (row_id),
        .rdy       (rdy),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic mem_t pattern(input logic [AW-1:0] a);
        mem_t p;
        for (int k = 0; k < NC; k++) begin
            p[k][95:64] = 32'hA500_0000 | (32'(a) << 8) | 32'(k);
            p[k][63:32] = 32'hC000_0000 | (32'(a) << 4) | 32'(k);
            p[k][31:0]  = 32'h0001_0000 | (32'(a) << 2) | 32'(k);
        end
        return p;
    endfunction

    function automatic lanes_t field(input mem_t p, input int lo);
        lanes_t f;
        for (int k = 0; k < NC; k++) f[k] = p[k][lo +: 32];
        return f;
    endfunction

    // Memory: data for the address strobed last cycle, junk otherwise.
    always @(posedge clk) begin
        if (mif.mem_rd) mif.mem_rdata <= pattern(mif.mem_addr);
        else            mif.mem_rdata <= {NC{96'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF}};
    end

    // Record reads and emitted groups.
    always @(negedge clk) begin
        if (mif.mem_rd) begin
            rd_addr_q.push_back(int'(mif.mem_addr));
            rd_cyc_q.push_back(cyc);
        end
        if (rdy) begin
            out_cyc_q.push_back(cyc);
            out_val_q.push_back(values);
            out_col_q.push_back(col_id);
            out_row_q.push_back(row_id);
        end
    end

    // Called at a negedge; returns at the following negedge with start dropped.
    task automatic pulse_start(input logic [AW-1:0] b, input logic [31:0] n, output int s);
        start = 1'b1;
        base_addr = b;
        nnz = n;
        s = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Returns the cycle done was first seen, or -1 if it never came.
    task automatic wait_done(output int dc);
        dc = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done) begin
                dc = cyc;
                return;
            end
        end
    endtask

    task automatic test_reset();
        tests_run++;
        if ({mif.mem_rd, mif.mem_addr, rdy, busy, done} !== '0 || values !== '0 || col_id !== '0 || row_id !== '0) begin
            tests_failed++;
            $display("FAIL reset_held: rd=%b addr=%h rdy=%b busy=%b done=%b val=%h col=%h row=%h, want all zero",
                     mif.mem_rd, mif.mem_addr, rdy, busy, done, values, col_id, row_id);
        end
        rst_l = 1'b1;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({mif.mem_rd, rdy, busy, done} !== 4'b0000 || row_id !== '0 || values !== '0) begin
            tests_failed++;
            $display("FAIL reset_idle: rd/rdy/busy/done=%b row=%h val=%h, want 0000 and zero lanes",
                     {mif.mem_rd, rdy, busy, done}, row_id, values);
        end
    endtask

    task automatic test_full();
        int s, dc, r0, o0;
        mem_t p;
        r0 = rd_addr_q.size();
        o0 = out_cyc_q.size();
        pulse_start(10'h010, 32'd8, s);
        tests_run++;
        if ({busy, done, rdy, mif.mem_rd} !== 4'b1001 || row_id !== '0) begin
            tests_failed++;
            $display("FAIL full_first_issue: busy/done/rdy/rd=%b row=%h, want 1001 and zero rows",
                     {busy, done, rdy, mif.mem_rd}, row_id);
        end
        wait_done(dc);
        tests_run++;
        if (dc !== s + 5) begin
            tests_failed++;
            $display("FAIL full_done_cycle: got %0d want %0d", dc, s + 5);
        end
        tests_run++;
        if (rd_addr_q.size() - r0 != 2) begin
            tests_failed++;
            $display("FAIL full_read_count: got %0d want 2", rd_addr_q.size() - r0);
        end else if (rd_addr_q[r0] != 'h010 || rd_addr_q[r0+1] != 'h011 || rd_cyc_q[r0] != s + 1 || rd_cyc_q[r0+1] != s + 2) begin
            tests_failed++;
            $display("FAIL full_read_seq: got %h@%0d %h@%0d want 010@%0d 011@%0d",
                     rd_addr_q[r0], rd_cyc_q[r0], rd_addr_q[r0+1], rd_cyc_q[r0+1], s + 1, s + 2);
        end
        tests_run++;
        if (out_cyc_q.size() - o0 != 2) begin
            tests_failed++;
            $display("FAIL full_out_count: got %0d want 2", out_cyc_q.size() - o0);
        end else begin
            for (int i = 0; i < 2; i++) begin
                p = pattern(AW'(32'h010 + i));
                tests_run++;
                if (out_cyc_q[o0+i] != s + 3 + i || out_val_q[o0+i] !== field(p, 64) ||
                    out_col_q[o0+i] !== field(p, 32) || out_row_q[o0+i] !== field(p, 0)) begin
                    tests_failed++;
                    $display("FAIL full_group%0d: cyc=%0d val=%h col=%h row=%h want cyc=%0d val=%h col=%h row=%h",
                             i, out_cyc_q[o0+i], out_val_q[o0+i], out_col_q[o0+i], out_row_q[o0+i],
                             s + 3 + i, field(p, 64), field(p, 32), field(p, 0));
                end
            end
        end
        tests_run++;
        if (rdy !== 1'b0 || busy !== 1'b0 || row_id !== SENT || values !== '0 || col_id !== '0) begin
            tests_failed++;
            $display("FAIL full_done_outputs: rdy=%b busy=%b row=%h val=%h col=%h want rdy=0 busy=0 row=%h zero val/col",
                     rdy, busy, row_id, values, col_id, SENT);
        end
        @(negedge clk);
        tests_run++;
        if (done !== 1'b1 || rdy !== 1'b0 || row_id !== SENT || mif.mem_rd !== 1'b0) begin
            tests_failed++;
            $display("FAIL full_done_hold: done=%b rdy=%b rd=%b row=%h want 1 0 0 %h", done, rdy, mif.mem_rd, row_id, SENT);
        end
    endtask

    task automatic test_partial();
        int s, dc, o0;
        mem_t p0, p1;
        lanes_t ev, ec, er;
        o0 = out_cyc_q.size();
        pulse_start(10'h020, 32'd5, s);
        wait_done(dc);
        tests_run++;
        if (dc !== s + 5) begin
            tests_failed++;
            $display("FAIL partial_done_cycle: got %0d want %0d", dc, s + 5);
        end
        p0 = pattern(10'h020);
        p1 = pattern(10'h021);
        ev = '0;
        ec = '0;
        er = SENT;
        ev[0] = p1[0][95:64];
        ec[0] = p1[0][63:32];
        er[0] = p1[0][31:0];
        tests_run++;
        if (out_cyc_q.size() - o0 != 2) begin
            tests_failed++;
            $display("FAIL partial_out_count: got %0d want 2", out_cyc_q.size() - o0);
        end else if (out_val_q[o0] !== field(p0, 64) || out_row_q[o0] !== field(p0, 0)) begin
            tests_failed++;
            $display("FAIL partial_group0: val=%h row=%h want val=%h row=%h",
                     out_val_q[o0], out_row_q[o0], field(p0, 64), field(p0, 0));
        end
        tests_run++;
        if (out_cyc_q.size() - o0 != 2) begin
            tests_failed++;
            $display("FAIL partial_tail_missing: got %0d groups want 2", out_cyc_q.size() - o0);
        end else if (out_val_q[o0+1] !== ev || out_col_q[o0+1] !== ec || out_row_q[o0+1] !== er) begin
            tests_failed++;
            $display("FAIL partial_tail: val=%h col=%h row=%h want val=%h col=%h row=%h",
                     out_val_q[o0+1], out_col_q[o0+1], out_row_q[o0+1], ev, ec, er);
        end
    endtask

    task automatic test_zero();
        int s, dc, r0, o0;
        r0 = rd_addr_q.size();
        o0 = out_cyc_q.size();
        pulse_start(10'h030, 32'd0, s);
        tests_run++;
        if ({busy, done, rdy, mif.mem_rd} !== 4'b1000 || row_id !== '0) begin
            tests_failed++;
            $display("FAIL zero_drain: busy/done/rdy/rd=%b row=%h want 1000 and zero rows",
                     {busy, done, rdy, mif.mem_rd}, row_id);
        end
        wait_done(dc);
        tests_run++;
        if (dc !== s + 2 || rd_addr_q.size() != r0 || out_cyc_q.size() != o0 || rdy !== 1'b0 || row_id !== SENT) begin
            tests_failed++;
            $display("FAIL zero_stream: done@%0d reads=%0d groups=%0d rdy=%b row=%h want done@%0d 0 0 0 %h",
                     dc, rd_addr_q.size() - r0, out_cyc_q.size() - o0, rdy, row_id, s + 2, SENT);
        end
    endtask

    task automatic test_wrap();
        int s, dc, r0, o0;
        mem_t p;
        r0 = rd_addr_q.size();
        o0 = out_cyc_q.size();
        pulse_start(10'h3FF, 32'd8, s);
        wait_done(dc);
        p = pattern(10'h000);
        tests_run++;
        if (rd_addr_q.size() - r0 != 2 || out_cyc_q.size() - o0 != 2) begin
            tests_failed++;
            $display("FAIL wrap_count: reads=%0d groups=%0d want 2 2", rd_addr_q.size() - r0, out_cyc_q.size() - o0);
        end else if (rd_addr_q[r0] != 'h3FF || rd_addr_q[r0+1] != 'h000 || out_val_q[o0+1] !== field(p, 64) || dc !== s + 5) begin
            tests_failed++;
            $display("FAIL wrap_addr: addr %h,%h val=%h done@%0d want 3ff,000 val=%h done@%0d",
                     rd_addr_q[r0], rd_addr_q[r0+1], out_val_q[o0+1], dc, field(p, 64), s + 5);
        end
    endtask

    task automatic test_ignore_start();
        int s, dc, s2, dc2, r0, o0;
        mem_t p;
        r0 = rd_addr_q.size();
        o0 = out_cyc_q.size();
        pulse_start(10'h100, 32'd12, s);
        @(negedge clk);
        start = 1'b1;
        base_addr = 10'h200;
        nnz = 32'd40;
        @(negedge clk);
        start = 1'b0;
        wait_done(dc);
        p = pattern(10'h102);
        tests_run++;
        if (rd_addr_q.size() - r0 != 3 || out_cyc_q.size() - o0 != 3) begin
            tests_failed++;
            $display("FAIL ignore_count: reads=%0d groups=%0d want 3 3", rd_addr_q.size() - r0, out_cyc_q.size() - o0);
        end else if (rd_addr_q[r0] != 'h100 || rd_addr_q[r0+2] != 'h102 || out_row_q[o0+2] !== field(p, 0) || dc !== s + 6) begin
            tests_failed++;
            $display("FAIL ignore_seq: addr %h..%h row=%h done@%0d want 100..102 row=%h done@%0d",
                     rd_addr_q[r0], rd_addr_q[r0+2], out_row_q[o0+2], dc, field(p, 0), s + 6);
        end
        r0 = rd_addr_q.size();
        pulse_start(10'h050, 32'd4, s2);
        tests_run++;
        if ({done, busy, rdy} !== 3'b010 || row_id !== '0) begin
            tests_failed++;
            $display("FAIL restart_clear: done/busy/rdy=%b row=%h want 010 and zero rows", {done, busy, rdy}, row_id);
        end
        wait_done(dc2);
        tests_run++;
        if (dc2 !== s2 + 4 || rd_addr_q.size() - r0 != 1) begin
            tests_failed++;
            $display("FAIL restart_stream: done@%0d reads=%0d want done@%0d 1 read", dc2, rd_addr_q.size() - r0, s2 + 4);
        end else if (rd_addr_q[r0] != 'h050) begin
            tests_failed++;
            $display("FAIL restart_addr: got %h want 050", rd_addr_q[r0]);
        end
    endtask

    task automatic test_reset_mid();
        int s, s2, dc, r0, o0;
        mem_t p;
        o0 = out_cyc_q.size();
        pulse_start(10'h060, 32'd16, s);
        @(negedge clk);
        rst_l = 1'b0;
        #1;
        tests_run++;
        if ({mif.mem_rd, mif.mem_addr, rdy, busy, done} !== '0 || values !== '0 || col_id !== '0 || row_id !== '0) begin
            tests_failed++;
            $display("FAIL midreset_async: rd=%b addr=%h rdy=%b busy=%b done=%b row=%h want all zero",
                     mif.mem_rd, mif.mem_addr, rdy, busy, done, row_id);
        end
        repeat (3) @(negedge clk);
        r0 = rd_addr_q.size();
        rst_l = 1'b1;
        repeat (5) @(negedge clk);
        tests_run++;
        if (out_cyc_q.size() != o0 || rd_addr_q.size() != r0 || busy !== 1'b0 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL midreset_discard: groups=%0d reads=%0d busy=%b done=%b want 0 0 0 0",
                     out_cyc_q.size() - o0, rd_addr_q.size() - r0, busy, done);
        end
        o0 = out_cyc_q.size();
        pulse_start(10'h070, 32'd4, s2);
        wait_done(dc);
        p = pattern(10'h070);
        tests_run++;
        if (dc !== s2 + 4 || out_cyc_q.size() - o0 != 1) begin
            tests_failed++;
            $display("FAIL post_reset_stream: done@%0d groups=%0d want done@%0d 1 group", dc, out_cyc_q.size() - o0, s2 + 4);
        end else if (out_cyc_q[o0] != s2 + 3 || out_val_q[o0] !== field(p, 64) || out_col_q[o0] !== field(p, 32)) begin
            tests_failed++;
            $display("FAIL post_reset_data: cyc=%0d val=%h col=%h want cyc=%0d val=%h col=%h",
                     out_cyc_q[o0], out_val_q[o0], out_col_q[o0], s2 + 3, field(p, 64), field(p, 32));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        test_reset();
        test_full();
        test_partial();
        test_zero();
        test_wrap();
        test_ignore_start();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/spmv_row_streamer.md
SPMV_ROW_STREAMER -- requirements
Module: spmv_row_streamer

Interface
REQ-001 Parameter NUM_CHANNELS, 4, number of parallel nonzero lanes.
REQ-002 Parameter MATRIX_SIZE, 128, row count; row_id==MATRIX_SIZE is the end-of-stream sentinel.
REQ-003 Parameter ADDR_W, 10, matrix memory word-address width.
REQ-004 clk  in  1  clock; all state changes on its rising edge.
REQ-005 rst_l  in  1  reset, asynchronous, active-low.
REQ-006 start  in  1  one-cycle pulse that begins a stream; sampled only in IDLE or DONE.
REQ-007 base_addr  in  ADDR_W  first group address; latched on accepted start.
REQ-008 nnz  in  32  total nonzero count; latched on accepted start.
REQ-009 mem_rd  out  1  read strobe to matrix memory.
REQ-010 mem_addr  out  ADDR_W  group address being read.
REQ-011 mem_rdata  in  NUM_CHANNELS x 96  per lane {value[95:64], col[63:32], row[31:0]}; valid exactly one cycle after mem_rd.
REQ-012 values  out  NUM_CHANNELS x 32  registered matrix values.
REQ-013 col_id  out  NUM_CHANNELS x 32  registered column indices.
REQ-014 row_id  out  NUM_CHANNELS x 32  registered row indices or sentinel.
REQ-015 rdy  out  1  registered; high when values/col_id/row_id carry a group.
REQ-016 busy  out  1  high in FETCH and DRAIN.
REQ-017 done  out  1  high in DONE.

Function
REQ-018 FSM states IDLE, FETCH, DRAIN, DONE; reset state IDLE.
REQ-019 Accepted start (IDLE or DONE): latch base_addr, nnz; groups G = ceil(nnz/NUM_CHANNELS), computed without 32-bit overflow; clear done; go FETCH if G>0, else DRAIN.
REQ-020 start while busy is ignored; no latch, no state change.
REQ-021 FETCH: one read per cycle, mem_rd=1, mem_addr=base_addr+g for g=0..G-1, wrapping modulo 2^ADDR_W; after issuing g=G-1 go DRAIN.
REQ-022 Group issued in cycle t appears on outputs in cycle t+2 with rdy=1; back-to-back groups give rdy high for G consecutive cycles.
REQ-023 Lane k of group g valid iff g*NUM_CHANNELS+k < nnz; valid lane outputs memory fields unmodified.
REQ-024 Invalid lane in a rdy=1 cycle: value=0, col_id=0, row_id=MATRIX_SIZE.
REQ-025 DRAIN lasts until last group has been output (2 cycles after last issue; 1 cycle when G=0), then DONE.
REQ-026 First cycle in DONE and thereafter: rdy=0, every lane row_id=MATRIX_SIZE, value=0, col_id=0, held until next accepted start.
REQ-027 IDLE and cycles with no group in flight before DONE: rdy=0, row_id=0, value=0, col_id=0 (never sentinel before stream end).
REQ-028 mem_rd=0 outside FETCH; mem_addr holds last value.
REQ-029 Restart from DONE: the DONE-cycle sentinel outputs drop to 0 in the cycle after start.

Reset
REQ-030 rst_l low, any cycle, incl. mid-FETCH: state IDLE, mem_rd=0, mem_addr=0, rdy=0, busy=0, done=0, all lanes values/col_id/row_id=0, counters cleared; in-flight read data discarded.
REQ-031 First start after rst_l deassertion is accepted normally.

Verification
REQ-032 nnz=8, base=0x010, NUM_CHANNELS=4 -> mem_rd at 0x010,0x011 consecutive; rdy high 2 cycles from issue+2; all lanes pass through; next cycle done=1, all row_id=128.
REQ-033 nnz=5 -> G=2; second group lane0 valid, lanes1-3 value=0,col=0,row_id=128 with rdy=1; then DONE.
REQ-034 nnz=0 -> no mem_rd; DONE 2 cycles after start; all row_id=128, rdy=0.
REQ-035 base=0x3FF, nnz=8 -> addresses 0x3FF then 0x000.
REQ-036 start pulsed during FETCH of nnz=12 -> ignored; exactly 3 reads, nnz unchanged; then restart from DONE with nnz=4 -> 1 read, done cleared then reasserted.
REQ-037 rst_l asserted one cycle after first mem_rd -> all outputs 0 immediately (async); no rdy ever from discarded read.
